pdec_rd_us: RTL and testbench

PDEC_RD_US -- requirements
Module: pdec_rd_us

---
 rtl/pdec_rd_us.sv | 195 +++++++++++++++++++
 tb/tb_pdec_rd_us.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdec_rd_us.sv
// -----------------------------------------------------------------------------
// pdec_rd_us -- partial-sum segment reader for the polar decoder.
//
// On a read start, the stage, per-path pointers and per-path validity codes
// are captured. For stage s the segment of width W = 2^s sitting at bits
// [2W-1:W] of each path's selected vector is streamed out to the calculator
// as ceil(W/BEAT_W) beats over a valid/ready handshake, LSB first.
// A stage whose segment would not fit in NUM_US bits is rejected with a
// one-cycle err+done pulse and no beats.
//
// Configuration macro:
//   PDEC_US_RD_CKZERO_EN  defined   -> CK paths (code 0) output zero payload
//                         undefined -> CK paths output the segment like
//                                      valid paths; only code 3 is zeroed
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ctrl2rus_rd_st      one-cycle read start
//   cur_stage[3:0]      tree stage of the segment to read
//   path_valid[15:0]    2-bit code per path (3 invalid, 0 CK, 1 valid)
//   rus_ptr[23:0]       3-bit source vector index per path
//   uus2rdc_us_data     eight NUM_US-bit partial-sum vectors
//   rus2cal_us_vld      beat valid
//   cal2rus_us_rdy      consumer ready
//   rus2cal_us_data     beat payload, BEAT_W bits per path
//   rus2cal_us_last     final beat of the read
//   rus2ctrl_rd_done    one-cycle completion pulse
//   rus2ctrl_rd_err     one-cycle stage-out-of-range pulse
//   pdec_clk_en7        clock-gate enable for this block's consumers
//
// FSM states:
//   state | meaning
//   IDLE  | waiting for ctrl2rus_rd_st
//   RD    | streaming beats, one held until vld&rdy
//   DONE  | one cycle, rus2ctrl_rd_done asserted
// -----------------------------------------------------------------------------
module pdec_rd_us #(
   parameter int NUM_US = 256,
   parameter int BEAT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ctrl2rus_rd_st,
   input  logic [3:0]            cur_stage,
   input  logic [15:0]           path_valid,
   input  logic [23:0]           rus_ptr,
   input  logic [NUM_US*8-1:0]   uus2rdc_us_data,
   output logic                  rus2cal_us_vld,
   input  logic                  cal2rus_us_rdy,
   output logic [8*BEAT_W-1:0]   rus2cal_us_data,
   output logic                  rus2cal_us_last,
   output logic                  rus2ctrl_rd_done,
   output logic                  rus2ctrl_rd_err,
   output logic                  pdec_clk_en7
);

   localparam int         LOG_US    = $clog2(NUM_US);
   localparam int         LOG_BW    = $clog2(BEAT_W);
   localparam int         CNT_W     = LOG_US + 1;
   localparam logic [4:0] STAGE_LIM = 5'(LOG_US);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   logic [3:0]        stage_q;
   logic [23:0]       ptr_q;
   logic [15:0]       pv_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              stage_ok;
   logic              sel_live;
   logic [3:0]        stage_sel;
   logic [23:0]       ptr_sel;
   logic [15:0]       pv_sel;
   logic [CNT_W-1:0]  idx_sel;
   logic [31:0]       seg_w;
   logic [31:0]       nbeats;
   logic [31:0]       beat_off;
   logic [31:0]       base;
   logic [NUM_US-1:0] vec;
   logic [NUM_US-1:0] shifted;
   logic [1:0]        code;
   logic              blank;
   logic [8*BEAT_W-1:0] beat_nxt;
   logic              last_nxt;

   // stage s is legal while 2^(s+1) <= NUM_US, i.e. s < log2(NUM_US)
   assign stage_ok = ({1'b0, cur_stage} < STAGE_LIM);

   // In IDLE the next beat is beat 0 of the read being started, so it is
   // built from the live request fields; otherwise from the captured copies.
   assign sel_live = (state == IDLE);

   always_comb begin
      stage_sel = sel_live ? cur_stage  : stage_q;
      ptr_sel   = sel_live ? rus_ptr    : ptr_q;
      pv_sel    = sel_live ? path_valid : pv_q;
      idx_sel   = sel_live ? '0 : cnt_q + CNT_W'(1);

      seg_w    = 32'd1 << stage_sel;
      nbeats   = ((seg_w >> LOG_BW) == 32'd0) ? 32'd1 : (seg_w >> LOG_BW);
      last_nxt = (32'(idx_sel) == (nbeats - 32'd1));
      beat_off = 32'(idx_sel) << LOG_BW;
      base     = seg_w + beat_off;

      beat_nxt = '0;
      vec      = '0;
      shifted  = '0;
      code     = '0;
      blank    = 1'b0;
      for (int ii = 0; ii < 8; ii++) begin
         vec     = uus2rdc_us_data[32'(ptr_sel[3*ii +: 3]) * NUM_US +: NUM_US];
         shifted = vec >> base;
         code    = pv_sel[2*ii +: 2];
`ifdef PDEC_US_RD_CKZERO_EN
         blank   = (code == 2'd3) || (code == 2'd0);
`else
         blank   = (code == 2'd3);
`endif
         // bits past the end of a short segment (W < BEAT_W) stay zero
         for (int j = 0; j < BEAT_W; j++) begin
            if (!blank && ((32'(j) + beat_off) < seg_w)) begin
               beat_nxt[ii*BEAT_W + j] = shifted[j];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         stage_q          <= '0;
         ptr_q            <= '0;
         pv_q             <= '0;
         cnt_q            <= '0;
         rus2cal_us_vld   <= 1'b0;
         rus2cal_us_data  <= '0;
         rus2cal_us_last  <= 1'b0;
         rus2ctrl_rd_done <= 1'b0;
         rus2ctrl_rd_err  <= 1'b0;
      end else begin
         rus2ctrl_rd_done <= 1'b0;
         rus2ctrl_rd_err  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (ctrl2rus_rd_st) begin
                  if (stage_ok) begin
                     stage_q         <= cur_stage;
                     ptr_q           <= rus_ptr;
                     pv_q            <= path_valid;
                     cnt_q           <= '0;
                     rus2cal_us_vld  <= 1'b1;
                     rus2cal_us_data <= beat_nxt;
                     rus2cal_us_last <= last_nxt;
                     state           <= RD;
                  end else begin
                     rus2ctrl_rd_err  <= 1'b1;
                     rus2ctrl_rd_done <= 1'b1;
                  end
               end
            end
            RD: begin
               if (cal2rus_us_rdy) begin
                  if (rus2cal_us_last) begin
                     rus2cal_us_vld   <= 1'b0;
                     rus2cal_us_data  <= '0;
                     rus2cal_us_last  <= 1'b0;
                     rus2ctrl_rd_done <= 1'b1;
                     state            <= DONE;
                  end else begin
                     cnt_q           <= cnt_q + CNT_W'(1);
                     rus2cal_us_data <= beat_nxt;
                     rus2cal_us_last <= last_nxt;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // rst_n term keeps the enable low while reset is held, even if a start
   // pulse is present on the input.
   assign pdec_clk_en7 = rst_n & (ctrl2rus_rd_st | (state != IDLE));

endmodule

// File: tb/tb_pdec_rd_us.sv
module tb_pdec_rd_us;

   localparam int NUM_US = 256;
   localparam int BEAT_W = 16;
   localparam int MAX_STAGE = 7;

`ifdef PDEC_US_RD_CKZERO_EN
   localparam bit CKZ = 1'b1;
`else
   localparam bit CKZ = 1'b0;
`endif

   logic                 clk;
   logic                 rst_n;
   logic                 rd_st;
   logic [3:0]           cur_stage;
   logic [15:0]          path_valid;
   logic [23:0]          rus_ptr;
   logic [NUM_US*8-1:0]  us_data;
   logic                 vld;
   logic                 rdy;
   logic [8*BEAT_W-1:0]  data;
   logic                 last;
   logic                 done;
   logic                 err;
   logic                 clk_en;

   logic [NUM_US-1:0]    vecs [8];

   typedef struct packed {
      logic [127:0] data;
      logic         last;
   } beat_t;

   typedef struct {
      logic [3:0]  stage;
      logic [23:0] ptr;
      logic [15:0] pv;
      int          mode;   // 0 rdy high, 1 stall 3 cycles on beat 2, 2 random rdy
      bit          exp_err;
   } vec_t;

   beat_t q[$];
   vec_t  tbl[11];

   int checks = 0;
   int errors = 0;

   pdec_rd_us #(.NUM_US(NUM_US), .BEAT_W(BEAT_W)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .ctrl2rus_rd_st   (rd_st),
      .cur_stage        (cur_stage),
      .path_valid       (path_valid),
      .rus_ptr          (rus_ptr),
      .uus2rdc_us_data  (us_data),
      .rus2cal_us_vld   (vld),
      .cal2rus_us_rdy   (rdy),
      .rus2cal_us_data  (data),
      .rus2cal_us_last  (last),
      .rus2ctrl_rd_done (done),
      .rus2ctrl_rd_err  (err),
      .pdec_clk_en7     (clk_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      us_data = '0;
      for (int v = 0; v < 8; v++) us_data[v*NUM_US +: NUM_US] = vecs[v];
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic randomize_vecs();
      for (int v = 0; v < 8; v++)
         for (int w = 0; w < NUM_US/32; w++) vecs[v][w*32 +: 32] = $urandom;
   endtask

   // Reference: walk each segment bit explicitly and place it in its beat.
   task automatic model_push(input logic [3:0] stage, input logic [23:0] ptr, input logic [15:0] pv);
      int w, nbt, p;
      logic [1:0] code;
      bit z;
      beat_t b;
      if (int'(stage) > MAX_STAGE) return;
      w   = 1 << stage;
      nbt = (w + BEAT_W - 1) / BEAT_W;
      for (int k = 0; k < nbt; k++) begin
         b.data = '0;
         for (int ii = 0; ii < 8; ii++) begin
            code = pv[2*ii +: 2];
            p    = int'(ptr[3*ii +: 3]);
            z    = (code == 2'd3) || (CKZ && code == 2'd0);
            for (int j = 0; j < BEAT_W; j++)
               if (!z && (k*BEAT_W + j) < w) b.data[ii*BEAT_W + j] = vecs[p][w + k*BEAT_W + j];
         end
         b.last = (k == nbt - 1);
         q.push_back(b);
      end
   endtask

   task automatic run_read(input logic [3:0] stage, input logic [23:0] ptr, input logic [15:0] pv,
                           input int mode, input bit exp_err);
      int done_n, err_n, stall, last_hs, post;
      bit hold, fin;
      logic [127:0] hold_d;
      logic hold_l;
      beat_t e;
      done_n = 0; err_n = 0; stall = 0; last_hs = -10; post = 0;
      hold = 0; fin = 0; hold_d = '0; hold_l = 0;
      @(posedge clk); #1;
      rd_st = 1'b1; cur_stage = stage; rus_ptr = ptr; path_valid = pv; rdy = 1'b1;
      #1 check("clk_en_on_start", clk_en, 1);
      @(posedge clk); #1;
      // scramble request fields: the read must use its captured copies
      rd_st = 1'b0; cur_stage = 4'($urandom); rus_ptr = 24'($urandom); path_valid = 16'($urandom);
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
         @(negedge clk);
         if (cyc == 0) check("first_vld", vld, !exp_err);
         if (hold) begin
            check("hold_vld", vld, 1);
            check("hold_data", data, hold_d);
            check("hold_last", last, hold_l);
            hold = 0;
         end
         if (vld && !rdy) begin
            hold = 1; hold_d = data; hold_l = last;
         end
         if (vld && rdy) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL extra_beat actual=%h required=none", data);
            end else begin
               e = q.pop_front();
               check("beat_data", data, e.data);
               check("beat_last", last, e.last);
            end
            last_hs = cyc;
         end
         if (err) err_n++;
         if (done) begin
            done_n++;
            check("done_timing", cyc, exp_err ? 0 : last_hs + 1);
            check("err_with_done", err, exp_err);
         end
         if (done_n > 0) begin
            post++;
            if (post > 2) fin = 1;
         end
         if (!fin) begin
            @(posedge clk); #1;
            if (mode == 1) begin
               rdy = !((checks >= 0) && (q.size() > 0) && stall < 3 && last_hs >= 0 && stall_on_beat2(stage, q.size()));
               if (!rdy) stall++;
            end else if (mode == 2) begin
               rdy = 1'($urandom_range(0, 1));
            end else begin
               rdy = 1'b1;
            end
         end
      end
      if (!fin) begin
         checks++; errors++;
         $display("FAIL read_timeout actual=no_done required=done");
      end
      check("done_count", done_n, 1);
      check("err_count", err_n, exp_err);
      check("beats_left", q.size(), 0);
      q.delete();
      rdy = 1'b1;
   endtask

   // True when the beat now presented is the second beat of the read.
   function automatic bit stall_on_beat2(input logic [3:0] stage, input int left);
      int nbt;
      nbt = ((1 << stage) + BEAT_W - 1) / BEAT_W;
      return (left == nbt - 1);
   endfunction

   initial begin
      rst_n = 1'b0; rd_st = 1'b0; cur_stage = '0; path_valid = '0; rus_ptr = '0; rdy = 1'b1;
      for (int v = 0; v < 8; v++) vecs[v] = '0;

      tbl[0]  = '{4'd0,  24'($urandom), 16'h5555, 2, 1'b0};
      tbl[1]  = '{4'd1,  24'($urandom), 16'h1B4E, 0, 1'b0};
      tbl[2]  = '{4'd2,  24'($urandom), 16'h0000, 2, 1'b0};
      tbl[3]  = '{4'd3,  24'($urandom), 16'hC3A5, 0, 1'b0};
      tbl[4]  = '{4'd4,  24'($urandom), 16'h5555, 2, 1'b0};
      tbl[5]  = '{4'd5,  24'($urandom), 16'hFFFF, 0, 1'b0};
      tbl[6]  = '{4'd6,  24'($urandom), 16'h1B4E, 2, 1'b0};
      tbl[7]  = '{4'd7,  24'($urandom), 16'h5555, 1, 1'b0};
      tbl[8]  = '{4'd8,  24'($urandom), 16'h5555, 0, 1'b1};
      tbl[9]  = '{4'd15, 24'($urandom), 16'h0000, 0, 1'b1};
      tbl[10] = '{4'd7,  24'($urandom), 16'hC3A5, 2, 1'b0};

      // reset state
      @(negedge clk);
      check("rst_vld", vld, 0);
      check("rst_data", data, 0);
      check("rst_last", last, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_clk_en", clk_en, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // stage 0: single bit 1 of vector 2
      vecs[2] = 256'h2;
      q.push_back('{{8{16'h0001}}, 1'b1});
      run_read(4'd0, {8{3'd2}}, 16'h5555, 0, 1'b0);

      // stage 5: two beats from bits [63:32]
      vecs[3] = {192'h0, 32'hA5A5_3C3C, 32'h0};
      q.push_back('{{8{16'h3C3C}}, 1'b0});
      q.push_back('{{8{16'hA5A5}}, 1'b1});
      run_read(4'd5, {8{3'd3}}, 16'h5555, 0, 1'b0);

      // path0 invalid, paths 1..7 CK
      vecs[1] = 256'hBEEF_0000;
      q.push_back('{(CKZ ? 128'h0 : {{7{16'hBEEF}}, 16'h0000}), 1'b1});
      run_read(4'd4, {8{3'd1}}, 16'h0003, 0, 1'b0);

      // reset in the middle of a stage-6 read, then a clean read
      randomize_vecs();
      @(posedge clk); #1;
      rd_st = 1'b1; cur_stage = 4'd6; rus_ptr = 24'h53_1A2C; path_valid = 16'h5555; rdy = 1'b1;
      @(posedge clk); #1 rd_st = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abort_pre_vld", vld, 1);
      rst_n = 1'b0;
      #1;
      check("abort_vld", vld, 0);
      check("abort_data", data, 0);
      check("abort_last", last, 0);
      check("abort_done", done, 0);
      check("abort_clk_en", clk_en, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_abort_idle", {vld, done, err}, 3'b000);
      end
      model_push(4'd6, 24'h53_1A2C, 16'h5555);
      run_read(4'd6, 24'h53_1A2C, 16'h5555, 0, 1'b0);

      // table-driven reads over random vectors
      for (int i = 0; i < 11; i++) begin
         randomize_vecs();
         model_push(tbl[i].stage, tbl[i].ptr, tbl[i].pv);
         run_read(tbl[i].stage, tbl[i].ptr, tbl[i].pv, tbl[i].mode, tbl[i].exp_err);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
